// File: rtl/bcd_scan_driver_pkg.sv
// rtl/bcd_scan_driver_pkg.sv - shared digit codes, converter states and double-dabble helper
package bcd_scan_driver_pkg;

    localparam logic [3:0] DIG_DASH  = 4'd10;
    localparam logic [3:0] DIG_BLANK = 4'd11;

    typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

    // Add-3 correction applied to every BCD nibble before each shift.
    function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_scan_driver_bin2bcd_seq.sv
// rtl/bcd_scan_driver_bin2bcd_seq.sv - sequential double-dabble, one magnitude bit per cycle
module bin2bcd_seq
    import bcd_scan_driver_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_mag,
    output logic              o_done,
    output logic [11:0]       o_bcd
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_shift;
    logic [11:0]       r_bcd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_run;
    logic [11:0]       w_adj;

    assign w_adj  = dabble_adjust(r_bcd);
    // o_done marks the cycle whose closing edge performs the final iteration.
    assign o_done = r_run && (r_cnt == CNT_W'(DATA_W - 1));
    assign o_bcd  = r_bcd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
        end else if (i_start) begin
            r_shift <= i_mag;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b1;
        end else if (r_run) begin
            r_bcd   <= {w_adj[10:0], r_shift[DATA_W-1]};
            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            r_cnt   <= r_cnt + 1'b1;
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bcd_scan_driver.sv
// rtl/bcd_scan_driver.sv - signed value to blanked BCD digits, multiplexed onto one bus
// Optional macro LEADING_ZERO_BLANK_EN: leading-zero blanking with floating sign.
module bcd_scan_driver
    import bcd_scan_driver_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int DATA_W      = 10,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   value,
    input  logic                load,
    output logic                busy,
    output logic [3:0]          bcd_out,
    output logic [N_DIGITS-1:0] an
);

    localparam int REF_W = $clog2(REFRESH_DIV);

    conv_state_t       r_state;
    conv_state_t       w_state_next;
    logic              w_start;
    logic              w_commit;
    logic              w_conv_done;
    logic [DATA_W-1:0] w_mag;
    logic [11:0]       w_bcd;
    logic              r_sign;
    logic [3:0]        w_pat   [4];
    logic [3:0]        r_digit [4];

    logic [REF_W-1:0]    r_refresh;
    logic [1:0]          r_idx;
    logic [1:0]          w_idx_next;
    logic                w_wrap;
    logic [N_DIGITS-1:0] r_an;
    logic [3:0]          r_bcd;

    // -512 negates to 10'b1000000000, which reads correctly as unsigned 512.
    assign w_mag = value[DATA_W-1] ? (~value + 1'b1) : value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (load) w_state_next = CONV;
            CONV:    if (w_conv_done) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_start  = (r_state == IDLE) && load;
        w_commit = (r_state == DONE);
        busy     = (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
        end else if (w_start) begin
            r_sign <= value[DATA_W-1];
        end
    end

    bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_mag   (w_mag),
        .o_done  (w_conv_done),
        .o_bcd   (w_bcd)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic w_show2;
    logic w_show1;
    assign w_show2 = (w_bcd[11:8] != 4'd0);
    assign w_show1 = w_show2 || (w_bcd[7:4] != 4'd0);

    always_comb begin
        w_pat[3] = DIG_BLANK;
        w_pat[2] = w_show2 ? w_bcd[11:8] : DIG_BLANK;
        w_pat[1] = w_show1 ? w_bcd[7:4]  : DIG_BLANK;
        w_pat[0] = w_bcd[3:0];
        // Dash sits just left of the most significant shown digit.
        if (r_sign) begin
            if (w_show2) begin
                w_pat[3] = DIG_DASH;
            end else if (w_show1) begin
                w_pat[2] = DIG_DASH;
            end else begin
                w_pat[1] = DIG_DASH;
            end
        end
    end
`else
    always_comb begin
        w_pat[3] = r_sign ? DIG_DASH : DIG_BLANK;
        w_pat[2] = w_bcd[11:8];
        w_pat[1] = w_bcd[7:4];
        w_pat[0] = w_bcd[3:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_digit[i] <= DIG_BLANK;
        end else if (w_commit) begin
            for (int i = 0; i < 4; i++) r_digit[i] <= w_pat[i];
        end
    end

    assign w_wrap     = (r_refresh == REF_W'(REFRESH_DIV - 1));
    assign w_idx_next = w_wrap ? (r_idx + 2'd1) : r_idx;

    // Select and code are registered together from the upcoming index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= 2'd0;
            r_an      <= ~N_DIGITS'(1);
            r_bcd     <= DIG_BLANK;
        end else begin
            r_refresh <= w_wrap ? '0 : (r_refresh + 1'b1);
            r_idx     <= w_idx_next;
            r_an      <= ~(N_DIGITS'(1) << w_idx_next);
            r_bcd     <= r_digit[w_idx_next];
        end
    end

    assign an      = r_an;
    assign bcd_out = r_bcd;

endmodule

// File: doc/bcd_scan_driver.md
Name: bcd_scan_driver

Overview:
- Upstream neighbour of the BCD-to-seven-segment decoder in the display path.
- Accepts a signed binary value on a load strobe and converts it to BCD with a sequential double-dabble, one bit per cycle.
- Applies leading-zero blanking and sign placement, then time-multiplexes the digits onto a shared bcd_out bus with active-low anode selects.
- bcd_out feeds the decoder directly; codes 0-9 are digits, 10 is dash, 11 is blank.

Parameters:
- N_DIGITS, 4, number of multiplexed digits. The design is fixed at 4; other values are not supported.
- DATA_W, 10, width of the signed input. Range is -512..511, so the magnitude fits in 3 digits plus a sign.
- REFRESH_DIV, 50000, clock cycles each digit stays selected. Must be >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- value  in  DATA_W  signed two's-complement value to display
- load  in  1  single-cycle request to convert value; sampled only when busy=0
- busy  out  1  high while a conversion is in progress
- bcd_out  out  4  code for the currently selected digit (0-9, 10 dash, 11 blank)
- an  out  N_DIGITS  one-hot active-low digit select; an[0] is the units digit

Behaviour:
Reset (rst high at a clk edge):
- FSM goes to IDLE; busy=0.
- All digit registers = 11 (blank).
- Refresh counter = 0; scan index = 0.
- an = 4'b1110; bcd_out = 11.
- Reset mid-conversion aborts it; the display stays blank until the next load.

Converter FSM: IDLE -> CONV -> DONE -> IDLE.
- IDLE: load=1 at edge k captures sign = value[DATA_W-1] and magnitude = |value|, a (DATA_W)-bit unsigned value. -512 gives 512. Go to CONV; busy=1 from edge k.
- CONV: DATA_W iterations, one per cycle. Each cycle, add 3 to every BCD nibble >= 5, then shift left by 1, bringing in the next magnitude MSB. Use a 3-nibble BCD scratch.
- DONE: one cycle. Compute the display pattern and write all 4 digit registers atomically at edge k+DATA_W+1, where busy returns to 0.
- Latency: load edge to new digits visible is DATA_W+1 = 11 cycles.
- load while busy=1 is ignored; there is no queuing.
- load in the same cycle busy falls is ignored. It is accepted from the next cycle.

Display pattern (with blanking):
- Digits 2..1 that are zero and have no nonzero digit above them become 11.
- Digit 0 is always shown.
- Negative values put 10 in the position just left of the most significant shown digit. Examples: -5 -> [11,11,10,5]; -512 -> [10,5,1,2].
- Negative zero cannot occur.
- Digit3 is 11 for non-negative values.

Scanner (runs independently of the FSM):
- The refresh counter counts 0..REFRESH_DIV-1 and wraps.
- On wrap, the index advances 0->1->2->3->0.
- an = ~(1<<index); bcd_out = digit_reg[index]. Both are registered and change on the same edge.
- Digit registers update mid-scan without glitching the scan order.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: blanking and floating sign as described above.
- Undefined: no blanking. Digits 2..0 are always shown, including zeros. Digit3 = 10 if negative, else 11. Examples: -5 -> [10,0,0,5]; 42 -> [11,0,4,2].

Decomposition:
- Shared package: localparams DIG_DASH=4'd10 and DIG_BLANK=4'd11, and the FSM state enum {IDLE, CONV, DONE}. The downstream decoder uses the same codes.
- One sub-module: bin2bcd_seq, holding the double-dabble iteration plus its start/done handshake.
- Blanking, sign placement and scanning stay in bcd_scan_driver.

Test Plan (REFRESH_DIV=4, macro defined unless noted):
- Reset, then scan 16 cycles -> bcd_out=11 on every digit; an cycles 1110,1101,1011,0111, each held 4 cycles.
- load with value=123 -> busy high 11 cycles; digits [11,1,2,3]; units digit shows 3 when an=1110.
- load with value=-5, then value=-512 -> [11,11,10,5] and [10,5,1,2].
- load with value=0, then value=511 -> [11,11,11,0] and [11,5,1,1].
- load 42, then load 99 while busy -> 99 is ignored; display [11,11,4,2]. A load 99 accepted after busy falls gives [11,11,9,9].
- rst asserted 5 cycles into converting 300 -> busy=0 and all digits 11 next cycle. Rerun with macro undefined and value=-5 -> [10,0,0,5].
